load_ext_stage: RTL and testbench

Registered load-data extension stage between the MEM and WB pipeline registers. It selects the addressed byte, halfword or word from the raw data-memory word and sign- or zero-extends it to DATA_W. It flags misaligned or unsupported accesses. A valid/ready handshake with a two-entry skid buffer lets WB stall without a combinational ready path back into MEM.

---
 rtl/ext_pkg.sv | 18 +
 rtl/ext_align.sv | 46 ++++
 rtl/load_ext_stage.sv | 113 +++++++++++
 tb/tb_load_ext_stage.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
// Shared definitions for the load-data extension stage:
// load op encodings, default widths and the address-LSB helper.
package ext_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int TAG_W_DEF  = 5;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_LH  = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;

    function automatic int addr_lsb(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/ext_align.sv
// Combinational select-and-extend of a loaded byte/half/word,
// with misalignment and reserved-op detection.
module ext_align
    import ext_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    localparam int ADDR_LSB = addr_lsb(DATA_W)
) (
    input  logic [DATA_W-1:0]   data_i,
    input  logic [ADDR_LSB-1:0] addr_i,
    input  logic [2:0]          op_i,
    output logic [DATA_W-1:0]   res_o,
    output logic                err_o
);

    logic [ADDR_LSB-1:0] half_addr;
    logic [7:0]          byte_v;
    logic [15:0]         half_v;

    always_comb begin
        half_addr    = addr_i;
        half_addr[0] = 1'b0;
        byte_v = 8'(data_i >> {addr_i, 3'b000});
        half_v = 16'(data_i >> {half_addr, 3'b000});
        res_o  = '0;
        err_o  = 1'b0;
        case (op_i)
            OP_LW: begin
                if (addr_i != '0) err_o = 1'b1;
                else              res_o = data_i;
            end
            OP_LB:  res_o = DATA_W'($signed(byte_v));
            OP_LBU: res_o = DATA_W'(byte_v);
            OP_LH: begin
                if (addr_i[0]) err_o = 1'b1;
                else           res_o = DATA_W'($signed(half_v));
            end
            OP_LHU: begin
                if (addr_i[0]) err_o = 1'b1;
                else           res_o = DATA_W'(half_v);
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_ext_stage.sv
// MEM->WB load extension stage: extends on the input side and
// registers the result through a main entry plus one skid entry.
module load_ext_stage
    import ext_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int TAG_W    = TAG_W_DEF,
    localparam int ADDR_LSB = addr_lsb(DATA_W)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [ADDR_LSB-1:0] in_addr,
    input  logic [2:0]          in_op,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_err
);

    logic [DATA_W-1:0] ext_data;
    logic              ext_err;

    ext_align #(.DATA_W(DATA_W)) u_align (
        .data_i (in_data),
        .addr_i (in_addr),
        .op_i   (in_op),
        .res_o  (ext_data),
        .err_o  (ext_err)
    );

    logic              main_vld_q, main_vld_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [TAG_W-1:0]  main_tag_q, main_tag_d;
    logic              main_err_q, main_err_d;
    logic              skid_vld_q, skid_vld_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [TAG_W-1:0]  skid_tag_q, skid_tag_d;
    logic              skid_err_q, skid_err_d;
    logic              accept;

    assign in_ready = reset & ~skid_vld_q;
    assign accept   = in_valid & in_ready;

    always_comb begin
        main_vld_d  = main_vld_q;
        main_data_d = main_data_q;
        main_tag_d  = main_tag_q;
        main_err_d  = main_err_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        skid_tag_d  = skid_tag_q;
        skid_err_d  = skid_err_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || out_ready) begin
            // A skid word blocks new input, so it always drains first.
            if (skid_vld_q) begin
                main_vld_d  = 1'b1;
                main_data_d = skid_data_q;
                main_tag_d  = skid_tag_q;
                main_err_d  = skid_err_q;
                skid_vld_d  = 1'b0;
            end else if (accept) begin
                main_vld_d  = 1'b1;
                main_data_d = ext_data;
                main_tag_d  = in_tag;
                main_err_d  = ext_err;
            end else begin
                main_vld_d  = 1'b0;
            end
        end else if (accept) begin
            skid_vld_d  = 1'b1;
            skid_data_d = ext_data;
            skid_tag_d  = in_tag;
            skid_err_d  = ext_err;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_vld_q  <= 1'b0;
            main_data_q <= '0;
            main_tag_q  <= '0;
            main_err_q  <= 1'b0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            skid_tag_q  <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            main_vld_q  <= main_vld_d;
            main_data_q <= main_data_d;
            main_tag_q  <= main_tag_d;
            main_err_q  <= main_err_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
            skid_tag_q  <= skid_tag_d;
            skid_err_q  <= skid_err_d;
        end
    end

    assign out_valid = main_vld_q;
    assign out_data  = main_data_q;
    assign out_tag   = main_tag_q;
    assign out_err   = main_err_q;

endmodule

// File: tb/tb_load_ext_stage.sv
// Directed bench for load_ext_stage at DATA_W=32 and DATA_W=64.
module tb_load_ext_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        flush, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [31:0] in_data, out_data;
    logic [1:0]  in_addr;
    logic [2:0]  in_op;
    logic [4:0]  in_tag, out_tag;

    logic        flush64, in_valid64, in_ready64, out_valid64;
    logic        out_ready64, out_err64;
    logic [63:0] in_data64, out_data64;
    logic [2:0]  in_addr64, in_op64;
    logic [4:0]  in_tag64, out_tag64;

    load_ext_stage #(.DATA_W(32), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_addr(in_addr), .in_op(in_op),
        .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_err(out_err)
    );

    load_ext_stage #(.DATA_W(64), .TAG_W(5)) dut64 (
        .clk(clk), .reset(reset), .flush(flush64),
        .in_valid(in_valid64), .in_ready(in_ready64),
        .in_data(in_data64), .in_addr(in_addr64), .in_op(in_op64),
        .in_tag(in_tag64), .out_valid(out_valid64),
        .out_ready(out_ready64), .out_data(out_data64),
        .out_tag(out_tag64), .out_err(out_err64)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_tests++;
        if ({out_valid, out_data, out_tag, out_err} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_out: got v=%0b d=%h t=%0d e=%0b want all 0",
                     out_valid, out_data, out_tag, out_err);
        end
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %0b want 0", in_ready);
        end
        n_tests++;
        if ({out_valid64, out_data64, out_err64, in_ready64} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_out64: got v=%0b d=%h e=%0b r=%0b want 0",
                     out_valid64, out_data64, out_err64, in_ready64);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: got rdy=%0b v=%0b want rdy=1 v=0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_ext32();
        logic [2:0]  op_t [11] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1,
                                   3'd4, 3'd3, 3'd0, 3'd6, 3'd2};
        logic [1:0]  ad_t [11] = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0,
                                   2'd2, 2'd1, 2'd2, 2'd0, 2'd1};
        logic [31:0] ex_t [11] = '{32'hFFFFFFAA, 32'h00000088,
                                   32'hFFFF8899, 32'h0000AABB,
                                   32'h8899AABB, 32'hFFFFFFBB,
                                   32'h00008899, 32'h0, 32'h0, 32'h0,
                                   32'h000000AA};
        logic        er_t [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        in_data   = 32'h8899AABB;
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1;
            in_op    = op_t[i];
            in_addr  = ad_t[i];
            in_tag   = 5'(i + 1);
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== ex_t[i] ||
                out_err !== er_t[i] || out_tag !== 5'(i + 1)) begin
                n_fail++;
                $display("FAIL ext32_%0d: got v=%0b d=%h e=%0b t=%0d want v=1 d=%h e=%0b t=%0d",
                         i, out_valid, out_data, out_err, out_tag,
                         ex_t[i], er_t[i], i + 1);
            end
        end
        in_valid = 1'b0;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ext32_drain: got v=%0b want 0", out_valid);
        end
    endtask

    task automatic test_ext64();
        logic [63:0] d1 = 64'h1122334455667788;
        logic [63:0] d2 = 64'h89ABCDEF01234567;
        logic [2:0]  op_t [11] = '{3'd3, 3'd1, 3'd2, 3'd4, 3'd0, 3'd0,
                                   3'd3, 3'd3, 3'd1, 3'd4, 3'd7};
        logic [2:0]  ad_t [11] = '{3'd6, 3'd0, 3'd7, 3'd2, 3'd0, 3'd4,
                                   3'd3, 3'd6, 3'd5, 3'd4, 3'd0};
        logic [63:0] ex_t [11] = '{64'h0000000000001122,
                                   64'hFFFFFFFFFFFFFF88,
                                   64'h0000000000000011,
                                   64'h0000000000005566,
                                   64'h1122334455667788,
                                   64'h0, 64'h0,
                                   64'hFFFFFFFFFFFF89AB,
                                   64'hFFFFFFFFFFFFFFCD,
                                   64'h000000000000CDEF,
                                   64'h0};
        logic        er_t [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                   1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        out_ready64 = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_valid64 = 1'b1;
            in_data64  = (i < 7) ? d1 : d2;
            in_op64    = op_t[i];
            in_addr64  = ad_t[i];
            in_tag64   = 5'(i + 20);
            tick();
            n_tests++;
            if (out_valid64 !== 1'b1 || out_data64 !== ex_t[i] ||
                out_err64 !== er_t[i] || out_tag64 !== 5'(i + 20)) begin
                n_fail++;
                $display("FAIL ext64_%0d: got v=%0b d=%h e=%0b t=%0d want v=1 d=%h e=%0b t=%0d",
                         i, out_valid64, out_data64, out_err64, out_tag64,
                         ex_t[i], er_t[i], i + 20);
            end
        end
        in_valid64 = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        in_op     = 3'd0;
        in_addr   = 2'd0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 5'd1;
        in_data   = 32'h10000001;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_tag !== 5'd1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: got v=%0b t=%0d rdy=%0b want 1,1,1",
                     out_valid, out_tag, in_ready);
        end
        in_tag  = 5'd2;
        in_data = 32'h10000002;
        tick();
        n_tests++;
        if (out_tag !== 5'd1 || out_data !== 32'h10000001 ||
            in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_skid: got t=%0d d=%h rdy=%0b want 1 10000001 0",
                     out_tag, out_data, in_ready);
        end
        in_tag  = 5'd3;
        in_data = 32'h10000003;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_tag !== 5'd1 ||
            out_data !== 32'h10000001 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_hold: got v=%0b t=%0d d=%h rdy=%0b want 1 1 10000001 0",
                     out_valid, out_tag, out_data, in_ready);
        end
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_tag !== 5'd2 ||
            out_data !== 32'h10000002 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: got v=%0b t=%0d d=%h rdy=%0b want 1 2 10000002 1",
                     out_valid, out_tag, out_data, in_ready);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_tag !== 5'd3 ||
            out_data !== 32'h10000003) begin
            n_fail++;
            $display("FAIL b2b_third: got v=%0b t=%0d d=%h want 1 3 10000003",
                     out_valid, out_tag, out_data);
        end
        in_valid = 1'b0;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_empty: got v=%0b want 0", out_valid);
        end
    endtask

    task automatic test_stall64();
        in_op64     = 3'd0;
        in_addr64   = 3'd0;
        out_ready64 = 1'b0;
        in_valid64  = 1'b1;
        in_tag64    = 5'd1;
        in_data64   = 64'hA;
        tick();
        in_tag64  = 5'd2;
        in_data64 = 64'hB;
        tick();
        in_valid64 = 1'b0;
        n_tests++;
        if (out_tag64 !== 5'd1 || out_data64 !== 64'hA ||
            in_ready64 !== 1'b0) begin
            n_fail++;
            $display("FAIL stall64_hold: got t=%0d d=%h rdy=%0b want 1 a 0",
                     out_tag64, out_data64, in_ready64);
        end
        out_ready64 = 1'b1;
        tick();
        n_tests++;
        if (out_valid64 !== 1'b1 || out_tag64 !== 5'd2 ||
            out_data64 !== 64'hB) begin
            n_fail++;
            $display("FAIL stall64_second: got v=%0b t=%0d d=%h want 1 2 b",
                     out_valid64, out_tag64, out_data64);
        end
        tick();
        n_tests++;
        if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1) begin
            n_fail++;
            $display("FAIL stall64_empty: got v=%0b rdy=%0b want 0 1",
                     out_valid64, in_ready64);
        end
    endtask

    task automatic test_flush();
        in_op     = 3'd0;
        in_addr   = 2'd0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 5'd4;
        tick();
        in_tag = 5'd5;
        tick();
        in_tag = 5'd6;
        flush  = 1'b1;
        tick();
        flush = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_full: got v=%0b rdy=%0b want 0 1",
                     out_valid, in_ready);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ghost: got v=%0b t=%0d want v=0",
                     out_valid, out_tag);
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 5'd7;
        tick();
        in_tag = 5'd8;
        flush  = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_accept: got v=%0b rdy=%0b want 0 1",
                     out_valid, in_ready);
        end
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_dropped: got v=%0b t=%0d want v=0",
                     out_valid, out_tag);
        end
    endtask

    task automatic test_reset_mid();
        in_op     = 3'd1;
        in_addr   = 2'd1;
        in_data   = 32'h8899AABB;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 5'd9;
        tick();
        in_tag = 5'd10;
        tick();
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, out_data, out_tag, out_err, in_ready} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%0b d=%h t=%0d e=%0b rdy=%0b want all 0",
                     out_valid, out_data, out_tag, out_err, in_ready);
        end
        tick();
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got rdy=%0b v=%0b want 0 0",
                     in_ready, out_valid);
        end
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%0b v=%0b want 1 0",
                     in_ready, out_valid);
        end
    endtask

    initial begin
        reset       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_addr     = '0;
        in_op       = '0;
        in_tag      = '0;
        out_ready   = 1'b1;
        flush64     = 1'b0;
        in_valid64  = 1'b0;
        in_data64   = '0;
        in_addr64   = '0;
        in_op64     = '0;
        in_tag64    = '0;
        out_ready64 = 1'b1;
        test_reset();
        test_ext32();
        test_back_to_back();
        test_flush();
        test_ext64();
        test_stall64();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
